// File: rtl/gt_rx_block_lock_pkg.sv
// Shared 64B/66B block-lock definitions: sync header codes, FSM states,
// and the counter-width helper used by the lock controller.
package gt_rx_block_lock_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // A valid 64B/66B sync header is either data (01) or control (10).
    function automatic logic sh_good(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gt_rx_block_lock_if.sv
// GT-side receive bundle for one channel: raw GT RX inputs plus the
// lock status and lock-qualified output stream of the block-lock controller.
interface gt_rx_block_lock_if;

    logic        i_rx_done;
    logic [63:0] i_rxdata;
    logic        i_rxdatavalid;
    logic [1:0]  i_rxheader;
    logic        i_rxheadervalid;

    logic        o_rxgearboxslip;
    logic        o_block_lock;
    logic        o_lock_lost;
    logic [15:0] o_slip_cnt;
    logic [63:0] o_rxdata;
    logic [1:0]  o_rxheader;
    logic        o_rxvalid;

    // GT / upstream side: drives the raw receive signals.
    modport master (
        output i_rx_done, i_rxdata, i_rxdatavalid, i_rxheader, i_rxheadervalid,
        input  o_rxgearboxslip, o_block_lock, o_lock_lost, o_slip_cnt,
               o_rxdata, o_rxheader, o_rxvalid
    );

    // Block-lock controller side.
    modport slave (
        input  i_rx_done, i_rxdata, i_rxdatavalid, i_rxheader, i_rxheadervalid,
        output o_rxgearboxslip, o_block_lock, o_lock_lost, o_slip_cnt,
               o_rxdata, o_rxheader, o_rxvalid
    );

endinterface

// File: rtl/gt_rx_block_lock.sv
// Per-channel 64B/66B receive block-lock controller (GT RX user-clock domain).
// Hunts for sync-header alignment by pulsing rxgearboxslip, declares lock after
// LOCK_CNT consecutive good headers, and drops lock when BAD_MAX bad headers
// land inside one WINDOW-beat monitoring window.
module gt_rx_block_lock
    import gt_rx_block_lock_pkg::*;
#(
    parameter int          LOCK_CNT  = 64,
    parameter int          WINDOW    = 64,
    parameter int          BAD_MAX   = 16,
    parameter int          SLIP_WAIT = 32,
    parameter logic [15:0] SLIP_SAT  = 16'hFFFF   // slip counter saturation value
) (
    input  logic               i_rx_clk,
    input  logic               i_rx_reset,
    gt_rx_block_lock_if.slave  rx
);

    localparam int GW = cnt_w(LOCK_CNT);
    localparam int WW = cnt_w(WINDOW);
    localparam int BW = cnt_w(BAD_MAX);
    localparam int SW = cnt_w(SLIP_WAIT);

    state_t        state;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [BW-1:0] bad_cnt;
    logic [SW-1:0] wait_cnt;
    logic [15:0]   slip_cnt;

    logic          gbslip;
    logic          block_lock;
    logic          lock_lost;
    logic          rxvalid;
    logic [63:0]   rxdata_q;
    logic [1:0]    rxheader_q;

    logic          hdr_good;
    logic          hdr_bad;

    // Header classification; beats without headervalid are neither good nor bad.
    assign hdr_good = rx.i_rxheadervalid &  sh_good(rx.i_rxheader);
    assign hdr_bad  = rx.i_rxheadervalid & ~sh_good(rx.i_rxheader);

    // Datapath: data and header are re-registered every cycle, lock or not.
    always_ff @(posedge i_rx_clk) begin
        if (i_rx_reset) begin
            rxdata_q   <= '0;
            rxheader_q <= '0;
        end else begin
            rxdata_q   <= rx.i_rxdata;
            rxheader_q <= rx.i_rxheader;
        end
    end

    // Lock FSM with its good/window/bad/wait counters and registered status outputs.
    always_ff @(posedge i_rx_clk) begin
        if (i_rx_reset) begin
            state      <= ST_IDLE;
            good_cnt   <= '0;
            win_cnt    <= '0;
            bad_cnt    <= '0;
            wait_cnt   <= '0;
            slip_cnt   <= '0;
            gbslip     <= 1'b0;
            block_lock <= 1'b0;
            lock_lost  <= 1'b0;
            rxvalid    <= 1'b0;
        end else begin
            gbslip    <= 1'b0;
            lock_lost <= 1'b0;
            rxvalid   <= rx.i_rxdatavalid & (state == ST_LOCKED) & rx.i_rx_done;

            // The slip pulse is issued from the SLIP cycle even if rx_done drops
            // at the same time, so a decided slip is never lost.
            if (state == ST_SLIP) begin
                gbslip <= 1'b1;
                if (slip_cnt != SLIP_SAT)
                    slip_cnt <= slip_cnt + 16'd1;
            end

            if (!rx.i_rx_done) begin
                state      <= ST_IDLE;
                block_lock <= 1'b0;
                good_cnt   <= '0;
                win_cnt    <= '0;
                bad_cnt    <= '0;
                wait_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_SEARCH;
                        good_cnt <= '0;
                    end
                    ST_SEARCH: begin
                        if (hdr_good) begin
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state      <= ST_LOCKED;
                                block_lock <= 1'b1;
                                good_cnt   <= '0;
                                win_cnt    <= '0;
                                bad_cnt    <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else if (hdr_bad) begin
                            state    <= ST_SLIP;
                            good_cnt <= '0;
                        end
                    end
                    ST_SLIP: begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                    ST_WAIT: begin
                        // Gearbox settling time: headers are meaningless here.
                        if (wait_cnt == SW'(SLIP_WAIT - 1)) begin
                            state    <= ST_SEARCH;
                            wait_cnt <= '0;
                            good_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (rx.i_rxheadervalid) begin
                            // Loss of lock is tested first so it wins over a window end.
                            if (hdr_bad && bad_cnt == BW'(BAD_MAX - 1)) begin
                                state      <= ST_SLIP;
                                block_lock <= 1'b0;
                                lock_lost  <= 1'b1;
                                win_cnt    <= '0;
                                bad_cnt    <= '0;
                            end else if (win_cnt == WW'(WINDOW - 1)) begin
                                win_cnt <= '0;
                                bad_cnt <= '0;
                            end else begin
                                win_cnt <= win_cnt + 1'b1;
                                if (hdr_bad)
                                    bad_cnt <= bad_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx.o_rxgearboxslip = gbslip;
    assign rx.o_block_lock    = block_lock;
    assign rx.o_lock_lost     = lock_lost;
    assign rx.o_slip_cnt      = slip_cnt;
    assign rx.o_rxdata        = rxdata_q;
    assign rx.o_rxheader      = rxheader_q;
    assign rx.o_rxvalid       = rxvalid;

endmodule
